// File: rtl/pool_window_unit.sv
// Streaming pooling engine: collects WIN unsigned samples, then returns the
// floor average (restoring divide, one quotient bit per cycle) or the maximum.
module pool_window_unit #(
   parameter int DATA_W = 8,
   parameter int WIN    = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy
);

   localparam int EXT_W = (WIN > 1) ? $clog2(WIN) : 1;
   localparam int ACC_W = DATA_W + EXT_W;
   localparam int CNT_W = (WIN > 1) ? $clog2(WIN) : 1;
   localparam int DIV_W = $clog2(ACC_W + 1);
   // Remainder is always below WIN, so it fits one bit narrower than the accumulator.
   localparam int REM_W = ACC_W - 1;

   typedef enum logic [1:0] {
      ST_ACCUM  = 2'd0,
      ST_DIVIDE = 2'd1,
      ST_OUTPUT = 2'd2
   } state_t;

   // One restoring step: returns {quotient_bit, next_remainder}.
   function automatic logic [ACC_W-1:0] div_step(input logic [REM_W-1:0] rem,
                                                 input logic             msb);
      logic [ACC_W-1:0] shifted;
      shifted = {rem, msb};
      if (shifted >= ACC_W'(WIN)) begin
         div_step = {1'b1, REM_W'(shifted - ACC_W'(WIN))};
      end else begin
         div_step = {1'b0, shifted[REM_W-1:0]};
      end
   endfunction

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [REM_W-1:0]    rem_q, rem_d;
   logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
   logic                mode_q, mode_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;
   logic                in_ready_q, in_ready_d;
   logic                busy_q, busy_d;

   logic [ACC_W-1:0]    in_ext_s;
   logic                first_s;
   logic                win_mode_s;
   logic [ACC_W-1:0]    step_s;

   assign in_ext_s   = {{(ACC_W - DATA_W){1'b0}}, in_data};
   assign first_s    = (count_q == CNT_W'(0));
   assign win_mode_s = first_s ? mode : mode_q;
   assign step_s     = div_step(rem_q, acc_q[ACC_W-1]);

   // Next-state and datapath selection for the accumulate/divide/output sequence.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      acc_d      = acc_q;
      rem_d      = rem_q;
      div_cnt_d  = div_cnt_q;
      mode_d     = mode_q;
      out_data_d = out_data_q;
      if (clear) begin
         state_d   = ST_ACCUM;
         count_d   = CNT_W'(0);
         acc_d     = ACC_W'(0);
         rem_d     = REM_W'(0);
         div_cnt_d = DIV_W'(0);
      end else begin
         case (state_q)
            ST_ACCUM: begin
               if (in_valid) begin
                  if (first_s) begin
                     mode_d = mode;
                     acc_d  = in_ext_s;
                  end else if (mode_q) begin
                     acc_d = (in_ext_s > acc_q) ? in_ext_s : acc_q;
                  end else begin
                     acc_d = acc_q + in_ext_s;
                  end
                  if (count_q == CNT_W'(WIN - 1)) begin
                     count_d = CNT_W'(0);
                     if (win_mode_s) begin
                        state_d    = ST_OUTPUT;
                        out_data_d = acc_d[DATA_W-1:0];
                     end else begin
                        state_d   = ST_DIVIDE;
                        rem_d     = REM_W'(0);
                        div_cnt_d = DIV_W'(0);
                     end
                  end else begin
                     count_d = count_q + CNT_W'(1);
                  end
               end else begin
                  count_d = count_q;
               end
            end
            ST_DIVIDE: begin
               // Quotient bits shift into the accumulator as the dividend shifts out.
               rem_d = step_s[REM_W-1:0];
               acc_d = {acc_q[ACC_W-2:0], step_s[ACC_W-1]};
               if (div_cnt_q == DIV_W'(ACC_W - 1)) begin
                  state_d    = ST_OUTPUT;
                  div_cnt_d  = DIV_W'(0);
                  out_data_d = acc_d[DATA_W-1:0];
               end else begin
                  div_cnt_d = div_cnt_q + DIV_W'(1);
               end
            end
            ST_OUTPUT: begin
               if (out_ready) begin
                  state_d = ST_ACCUM;
                  acc_d   = ACC_W'(0);
               end else begin
                  state_d = ST_OUTPUT;
               end
            end
            default: begin
               state_d = ST_ACCUM;
               count_d = CNT_W'(0);
               acc_d   = ACC_W'(0);
            end
         endcase
      end
      out_valid_d = (state_d == ST_OUTPUT);
      in_ready_d  = (state_d == ST_ACCUM);
      busy_d      = (state_d != ST_ACCUM) || (count_d != CNT_W'(0));
   end

   // State, datapath and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ACCUM;
         count_q     <= CNT_W'(0);
         acc_q       <= ACC_W'(0);
         rem_q       <= REM_W'(0);
         div_cnt_q   <= DIV_W'(0);
         mode_q      <= 1'b0;
         out_data_q  <= DATA_W'(0);
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         acc_q       <= acc_d;
         rem_q       <= rem_d;
         div_cnt_q   <= div_cnt_d;
         mode_q      <= mode_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = busy_q;

endmodule
